// File: rtl/dsp_pkg.sv
// Shared definitions for dsp_* blocks: FIR sequencer states, accumulator sizing, reset coefficients.
package dsp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_t;

  // Guard bits cover the worst-case growth of summing ntaps full-scale products.
  function automatic int calc_aw(input int ws, input int cws, input int ntaps);
    return ws + cws + $clog2(ntaps);
  endfunction

  // Unity gain on the centre tap, zero elsewhere: output is the input delayed (ntaps-1)/2 samples.
  function automatic logic signed [31:0] passthru_coef(input int tap, input int ntaps, input int frac);
    return (tap == (ntaps - 1) / 2) ? (32'sd1 <<< frac) : 32'sd0;
  endfunction

endpackage

// File: rtl/dsp_coef_ram.sv
// NBANK x NTAPS coefficient store, async reset to pass-through, one write port and one combinational read.
// Writes into the bank currently being filtered are refused (no ack); the writer is expected to retry.
module dsp_coef_ram
  import dsp_pkg::*;
#(
  parameter int CWS   = 16,
  parameter int NTAPS = 15,
  parameter int NBANK = 8,
  parameter int FRAC  = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_we,
  input  logic [$clog2(NBANK)-1:0]   i_wbank,
  input  logic [$clog2(NTAPS)-1:0]   i_waddr,
  input  logic [CWS-1:0]             i_wdata,
  input  logic                       i_busy,
  input  logic [$clog2(NBANK)-1:0]   i_act_bank,
  input  logic [$clog2(NBANK)-1:0]   i_rbank,
  input  logic [$clog2(NTAPS)-1:0]   i_rtap,
  output logic [CWS-1:0]             o_rdata,
  output logic                       o_ack
);

  logic [CWS-1:0] r_mem [NBANK][NTAPS];
  logic           r_ack;
  logic           w_wr;

  assign w_wr = i_we
             && (32'(i_waddr) < NTAPS)
             && (32'(i_wbank) < NBANK)
             && !(i_busy && (i_wbank == i_act_bank));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack <= 1'b0;
      for (int b = 0; b < NBANK; b++) begin
        for (int t = 0; t < NTAPS; t++) begin
          r_mem[b][t] <= CWS'(passthru_coef(t, NTAPS, FRAC));
        end
      end
    end else begin
      r_ack <= w_wr;
      if (w_wr) begin
        r_mem[i_wbank][i_waddr] <= i_wdata;
      end
    end
  end

  assign o_rdata = r_mem[i_rbank][i_rtap];
  assign o_ack   = r_ack;

endmodule

// File: rtl/dsp_fir_mac.sv
// Time-multiplexed FIR/equaliser: one MAC walks NTAPS taps; oValid NTAPS+1 edges after accept, oReady low while busy.
// Samples offered while busy are dropped (oDrop). Define DSP_FIR_MAC_SAT_EN for saturating output and sticky oSat.
module dsp_fir_mac
  import dsp_pkg::*;
#(
  parameter int WS    = 16,
  parameter int CWS   = 16,
  parameter int NTAPS = 15,
  parameter int NBANK = 8,
  parameter int FRAC  = 12
) (
  input  logic                       iCLK,
  input  logic                       iRST_N,
  input  logic [WS-1:0]              iIn,
  input  logic                       iValid,
  output logic                       oReady,
  input  logic [$clog2(NBANK)-1:0]   iIndex,
  output logic [WS-1:0]              oOut,
  output logic                       oValid,
  output logic                       oDrop,
  input  logic                       iCoefWe,
  input  logic [$clog2(NBANK)-1:0]   iCoefBank,
  input  logic [$clog2(NTAPS)-1:0]   iCoefAddr,
  input  logic [CWS-1:0]             iCoefData,
`ifdef DSP_FIR_MAC_SAT_EN
  output logic                       oCoefAck,
  output logic                       oSat
`else
  output logic                       oCoefAck
`endif
);

  localparam int AW = calc_aw(WS, CWS, NTAPS);
  localparam int BW = $clog2(NBANK);
  localparam int TW = $clog2(NTAPS);

  fir_state_t                 r_state;
  fir_state_t                 w_next;
  logic signed [WS-1:0]       r_x [NTAPS];
  logic [BW-1:0]              r_bank;
  logic [TW-1:0]              r_k;
  logic signed [AW-1:0]       r_acc;
  logic [WS-1:0]              r_out;
  logic                       r_valid;
  logic                       r_drop;

  logic                       w_accept;
  logic                       w_busy;
  logic [CWS-1:0]             w_coef;
  logic signed [WS+CWS-1:0]   w_prod;
  logic signed [AW-1:0]       w_prod_ext;
  logic [WS-1:0]              w_res;

  assign w_busy     = (r_state != IDLE);
  assign w_accept   = !w_busy && iValid;
  assign w_prod     = r_x[r_k] * $signed(w_coef);
  assign w_prod_ext = {{(AW-WS-CWS){w_prod[WS+CWS-1]}}, w_prod};

  dsp_coef_ram #(
    .CWS   (CWS),
    .NTAPS (NTAPS),
    .NBANK (NBANK),
    .FRAC  (FRAC)
  ) u_coef_ram (
    .i_clk      (iCLK),
    .i_rst_n    (iRST_N),
    .i_we       (iCoefWe),
    .i_wbank    (iCoefBank),
    .i_waddr    (iCoefAddr),
    .i_wdata    (iCoefData),
    .i_busy     (w_busy),
    .i_act_bank (r_bank),
    .i_rbank    (r_bank),
    .i_rtap     (r_k),
    .o_rdata    (w_coef),
    .o_ack      (oCoefAck)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (iValid) w_next = MAC;
      MAC:     if (r_k == TW'(NTAPS - 1)) w_next = OUT;
      OUT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= IDLE;
    else         r_state <= w_next;
  end

`ifdef DSP_FIR_MAC_SAT_EN
  logic signed [AW-1:0] w_shift;
  logic                 w_clip;
  logic                 r_sat;

  // Out of range whenever the bits above the output sign bit are not all copies of it.
  assign w_shift = r_acc >>> FRAC;
  assign w_clip  = (w_shift[AW-1:WS-1] != {(AW-WS+1){w_shift[AW-1]}});
  assign w_res   = !w_clip         ? w_shift[WS-1:0] :
                   w_shift[AW-1]   ? {1'b1, {(WS-1){1'b0}}} :
                                     {1'b0, {(WS-1){1'b1}}};

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)                         r_sat <= 1'b0;
    else if ((r_state == OUT) && w_clip) r_sat <= 1'b1;
  end

  assign oSat = r_sat;
`else
  assign w_res = r_acc[FRAC +: WS];
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < NTAPS; i++) r_x[i] <= '0;
      r_bank  <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_drop  <= iValid && w_busy;
      if (w_accept) begin
        for (int i = NTAPS - 1; i > 0; i--) r_x[i] <= r_x[i-1];
        r_x[0] <= iIn;
        r_bank <= (32'(iIndex) < NBANK) ? iIndex : '0;
        r_acc  <= '0;
        r_k    <= '0;
      end
      if (r_state == MAC) begin
        r_acc <= r_acc + w_prod_ext;
        r_k   <= r_k + TW'(1);
      end
      if (r_state == OUT) begin
        r_out   <= w_res;
        r_valid <= 1'b1;
      end
    end
  end

  assign oReady = !w_busy;
  assign oOut   = r_out;
  assign oValid = r_valid;
  assign oDrop  = r_drop;

endmodule
